samplerz_accept: RTL and testbench

SAMPLERZ_ACCEPT -- requirements
Module: samplerz_accept

---
 rtl/samplerz_pkg.sv | 15 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/samplerz_accept.sv | 134 +++++++++++++
 tb/tb_samplerz_accept.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/samplerz_pkg.sv
// rtl/samplerz_pkg.sv - shared state enum and default parameters for samplerz_accept
package samplerz_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int DEF_DEPTH        = 16;
  localparam int DEF_Z_W          = 16;
  localparam int DEF_CNT_W        = 32;
  localparam int DEF_FLUSH_CYCLES = 32;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-2 depth, simultaneous push/pop at any occupancy
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/samplerz_accept.sv
// rtl/samplerz_accept.sv - BerExp accept/reject stage: tags candidates, keeps accepted samples in order
module samplerz_accept
  import samplerz_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int Z_W          = DEF_Z_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cand_val_i,
  output logic             cand_rdy_o,
  input  logic [Z_W-1:0]   cand_z_i,
  output logic             ber_val_o,
  input  logic             ber_dout_val_i,
  input  logic             ber_w_i,
  output logic             z_val_o,
  input  logic             z_rdy_i,
  output logic [Z_W-1:0]   z_o,
  output logic             retry_o,
  output logic [CNT_W-1:0] acc_cnt_o,
  output logic [CNT_W-1:0] rej_cnt_o,
  output logic             err_o
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              FC_W       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [AW+1:0]   CREDIT_MAX = (AW+2)'(DEPTH);

  state_e           state_q, state_d;
  logic [FC_W-1:0]  flush_q, flush_d;
  logic             err_q, err_d;
  logic             retry_q, retry_d;
  logic [CNT_W-1:0] acc_q, acc_d, rej_q, rej_d;

  logic             tag_pop, tag_empty, tag_full;
  logic             out_push, out_pop, out_empty, out_full;
  logic [AW:0]      tag_cnt, out_cnt;
  logic [Z_W-1:0]   tag_head;
  logic [AW+1:0]    occ;
  logic             cand_rdy;

  // Credit covers in-flight tags plus undrained outputs, so every accept has a slot waiting.
  assign occ        = {1'b0, tag_cnt} + {1'b0, out_cnt};
  assign cand_rdy   = (state_q == ST_RUN) && (occ < CREDIT_MAX) && !tag_full && !out_full;
  assign cand_rdy_o = cand_rdy;
  assign ber_val_o  = cand_val_i && cand_rdy;
  assign z_val_o    = !out_empty;
  assign out_pop    = !out_empty && z_rdy_i;
  assign retry_o    = retry_q;
  assign acc_cnt_o  = acc_q;
  assign rej_cnt_o  = rej_q;
  assign err_o      = err_q;

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    err_d    = err_q;
    retry_d  = 1'b0;
    acc_d    = acc_q;
    rej_d    = rej_q;
    tag_pop  = 1'b0;
    out_push = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (flush_q == '0) state_d = ST_RUN;
        else               flush_d = flush_q - FC_W'(1);
      end
      ST_RUN: begin
        if (ber_dout_val_i) begin
          if (tag_empty) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            tag_pop = 1'b1;
            if (ber_w_i) begin
              out_push = 1'b1;
              if (acc_q != '1) acc_d = acc_q + CNT_W'(1);
            end else begin
              retry_d = 1'b1;
              if (rej_q != '1) rej_d = rej_q + CNT_W'(1);
            end
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      flush_q <= FC_W'(FLUSH_CYCLES - 1);
      err_q   <= 1'b0;
      retry_q <= 1'b0;
      acc_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
    end
  end

  sync_fifo #(.WIDTH(Z_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ber_val_o),
    .din_i   (cand_z_i),
    .pop_i   (tag_pop),
    .dout_o  (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full),
    .count_o (tag_cnt)
  );

  sync_fifo #(.WIDTH(Z_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (out_push),
    .din_i   (tag_head),
    .pop_i   (out_pop),
    .dout_o  (z_o),
    .empty_o (out_empty),
    .full_o  (out_full),
    .count_o (out_cnt)
  );

endmodule

// File: tb/tb_samplerz_accept.sv
// tb/tb_samplerz_accept.sv - bench for samplerz_accept with a queue-based reference and fixed-latency BerExp stand-in
module tb_samplerz_accept;

  localparam int DEPTH   = 16;
  localparam int Z_W     = 16;
  localparam int CNT_W   = 4;
  localparam int FLUSH   = 32;
  localparam int LAT     = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cand_val_i = 1'b0;
  logic [Z_W-1:0]   cand_z_i = '0;
  logic             ber_dout_val_i = 1'b0;
  logic             ber_w_i = 1'b0;
  logic             z_rdy_i = 1'b0;
  logic             cand_rdy_o, ber_val_o, z_val_o, retry_o, err_o;
  logic [Z_W-1:0]   z_o;
  logic [CNT_W-1:0] acc_cnt_o, rej_cnt_o;

  always #5 clk = ~clk;

  samplerz_accept #(.DEPTH(DEPTH), .Z_W(Z_W), .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk            (clk),
    .rst            (rst),
    .cand_val_i     (cand_val_i),
    .cand_rdy_o     (cand_rdy_o),
    .cand_z_i       (cand_z_i),
    .ber_val_o      (ber_val_o),
    .ber_dout_val_i (ber_dout_val_i),
    .ber_w_i        (ber_w_i),
    .z_val_o        (z_val_o),
    .z_rdy_i        (z_rdy_i),
    .z_o            (z_o),
    .retry_o        (retry_o),
    .acc_cnt_o      (acc_cnt_o),
    .rej_cnt_o      (rej_cnt_o),
    .err_o          (err_o)
  );

  int total = 0;
  int bad = 0;
  int gcyc = 0;
  int lcyc = 0;
  int retry_seen = 0;
  int acc_m = 0;
  int rej_m = 0;
  bit err_m = 1'b0;
  bit retry_m = 1'b0;
  logic [Z_W-1:0] tags[$];
  logic [Z_W-1:0] outq[$];
  logic [Z_W-1:0] popped[$];
  int due_c[$];
  bit due_w[$];
  bit w_plan[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_rdy();
    return (lcyc >= FLUSH) && !err_m && ((tags.size() + outq.size()) < DEPTH);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cand_val_i = 1'b0;
    z_rdy_i = 1'b0;
    ber_w_i = 1'b0;
    ber_dout_val_i = 1'b0;
    if (due_c.size() > 0 && due_c[0] == gcyc) begin
      ber_dout_val_i = 1'b1;
      void'(due_c.pop_front());
      void'(due_w.pop_front());
    end
    @(posedge clk); #1;
    gcyc++;
    rst = 1'b0;
    tags.delete();
    outq.delete();
    acc_m = 0;
    rej_m = 0;
    err_m = 1'b0;
    retry_m = 1'b0;
    lcyc = 0;
  endtask

  // One clock: drive, check outputs against the reference, then advance the reference.
  task automatic cyc(input bit cv, input logic [Z_W-1:0] z, input bit zr, input bit inj);
    bit rv, w, rdy, hs, nr;
    logic [Z_W-1:0] t;
    rv = 1'b0;
    w = 1'b0;
    if (due_c.size() > 0 && due_c[0] == gcyc) begin
      rv = 1'b1;
      void'(due_c.pop_front());
      w = due_w.pop_front();
    end else if (inj) begin
      rv = 1'b1;
      w = 1'($urandom_range(0, 1));
    end
    cand_val_i = cv;
    cand_z_i = z;
    ber_dout_val_i = rv;
    ber_w_i = w;
    z_rdy_i = zr;
    #1;
    rdy = model_rdy();
    hs = cv && rdy;
    chk("cand_rdy", 32'(cand_rdy_o), 32'(rdy));
    chk("ber_val", 32'(ber_val_o), 32'(hs));
    chk("z_val", 32'(z_val_o), 32'(outq.size() > 0));
    if (outq.size() > 0) chk("z_o", 32'(z_o), 32'(outq[0]));
    chk("retry", 32'(retry_o), 32'(retry_m));
    chk("acc_cnt", 32'(acc_cnt_o), 32'(acc_m));
    chk("rej_cnt", 32'(rej_cnt_o), 32'(rej_m));
    chk("err", 32'(err_o), 32'(err_m));
    if (retry_o === 1'b1) retry_seen++;

    if (hs) begin
      due_c.push_back(gcyc + LAT);
      if (w_plan.size() > 0) due_w.push_back(w_plan.pop_front());
      else                   due_w.push_back(1'($urandom_range(0, 1)));
    end
    if (zr && outq.size() > 0) begin
      popped.push_back(z_o);
      void'(outq.pop_front());
    end
    nr = 1'b0;
    if (lcyc >= FLUSH && !err_m && rv) begin
      if (tags.size() == 0) begin
        err_m = 1'b1;
      end else begin
        t = tags.pop_front();
        if (w) begin
          outq.push_back(t);
          if (acc_m < CNT_MAX) acc_m++;
        end else begin
          nr = 1'b1;
          if (rej_m < CNT_MAX) rej_m++;
        end
      end
    end
    if (hs) tags.push_back(z);
    retry_m = nr;
    @(posedge clk); #1;
    gcyc++;
    lcyc++;
  endtask

  initial begin
    // Reset values and flush window
    do_reset();
    chk("rst_cand_rdy", 32'(cand_rdy_o), 32'd0);
    chk("rst_ber_val", 32'(ber_val_o), 32'd0);
    chk("rst_z_val", 32'(z_val_o), 32'd0);
    chk("rst_z_o", 32'(z_o), 32'd0);
    chk("rst_retry", 32'(retry_o), 32'd0);
    chk("rst_acc", 32'(acc_cnt_o), 32'd0);
    chk("rst_rej", 32'(rej_cnt_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    for (int i = 0; i < FLUSH; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rdy_after_flush", 32'(cand_rdy_o), 32'd1);

    // 5, -3, 7 with accept/reject/accept
    w_plan = '{1'b1, 1'b0, 1'b1};
    popped.delete();
    retry_seen = 0;
    cyc(1'b1, Z_W'(5), 1'b1, 1'b0);
    cyc(1'b1, Z_W'(-3), 1'b1, 1'b0);
    cyc(1'b1, Z_W'(7), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("seq_len", 32'(popped.size()), 32'd2);
    chk("seq_z0", 32'(popped[0]), 32'(Z_W'(5)));
    chk("seq_z1", 32'(popped[1]), 32'(Z_W'(7)));
    chk("seq_retries", 32'(retry_seen), 32'd1);
    chk("seq_acc", 32'(acc_cnt_o), 32'd2);
    chk("seq_rej", 32'(rej_cnt_o), 32'd1);

    // Fill to DEPTH with the output stalled, then drain in order
    for (int i = 0; i < DEPTH; i++) w_plan.push_back(1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, Z_W'(100 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("full_rdy", 32'(cand_rdy_o), 32'd0);
    chk("full_acc_sat", 32'(acc_cnt_o), 32'(CNT_MAX));
    popped.delete();
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_len", 32'(popped.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) chk("drain_z", 32'(popped[i]), 32'(100 + i));
    chk("credit_back", 32'(cand_rdy_o), 32'd1);

    // Steady occupancy DEPTH-1 with push and reject in the same cycle
    do_reset();
    for (int i = 0; i < FLUSH; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    w_plan.delete();
    for (int i = 0; i < 11; i++) w_plan.push_back(1'b1);
    for (int i = 0; i < 30; i++) w_plan.push_back(1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b1, Z_W'($urandom), 1'b0, 1'b0);
    chk("occ15_rdy", 32'(cand_rdy_o), 32'd1);
    chk("occ15_outs", 32'(outq.size()), 32'd11);

    // Stray result with no tag outstanding; output keeps draining in HALT
    w_plan.delete();
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cyc(1'b1, Z_W'($urandom), 1'b1, (i % 3) == 0);
    chk("halt_err", 32'(err_o), 32'd1);
    chk("halt_rdy", 32'(cand_rdy_o), 32'd0);
    chk("halt_drained", 32'(z_val_o), 32'd0);

    // Reset with 4 in flight; their results land during FLUSH
    do_reset();
    for (int i = 0; i < FLUSH; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, Z_W'(200 + i), 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stale_z_val", 32'(z_val_o), 32'd0);
    chk("stale_acc", 32'(acc_cnt_o), 32'd0);
    chk("stale_rej", 32'(rej_cnt_o), 32'd0);
    chk("stale_err", 32'(err_o), 32'd0);

    // Random traffic
    for (int i = 0; i < FLUSH; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 99) < 60, Z_W'($urandom), $urandom_range(0, 99) < 70, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("end_empty", 32'(z_val_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
